mem_port_arbiter: RTL and testbench

Arbitrates the single-port unified memory between instruction fetch (stage one) and load/store (stage three) of the three-stage pipeline. Grants one requester at a time, sequences the memory handshake, and returns read data with a one-cycle done pulse. Data accesses have priority; a streak counter keeps fetch from starving. A watchdog aborts accesses the memory never acknowledges.

---
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Data has priority; a streak counter bounds fetch starvation; a watchdog aborts hung accesses.
module mem_port_arbiter #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 16,
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          halt_sys,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          fetch_wait,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);
    localparam logic [7:0] WDOG_LAST  = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [3:0]    streak_q, streak_d;
    logic [7:0]    wdog_q, wdog_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          i_done_q, i_done_d;
    logic          d_done_q, d_done_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          err_q, err_d;

    // A requester whose done pulse is visible now still holds req; mask it so it is not regranted.
    logic i_eff, d_eff, grant_i, grant_d;

    always_comb begin
        i_eff   = i_req & ~i_done_q;
        d_eff   = d_req & ~d_done_q;
        grant_d = d_eff & (~i_eff | (streak_q < STREAK_MAX));
        grant_i = i_eff & ~grant_d;
    end

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        wdog_d      = wdog_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        err_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!halt_sys) begin
                    if (grant_i || !i_req) begin
                        streak_d = '0;
                    end else if (grant_d && i_eff) begin
                        streak_d = streak_q + 4'd1;
                    end

                    if (grant_d) begin
                        state_d     = BUSY_D;
                        wdog_d      = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else if (grant_i) begin
                        state_d     = BUSY_I;
                        wdog_d      = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                    end
                end
            end

            BUSY_I, BUSY_D: begin
                // mem_ready takes precedence over an expiring watchdog in the same cycle.
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (state_q == BUSY_I) begin
                        i_done_d  = 1'b1;
                        i_rdata_d = mem_rdata;
                    end else begin
                        d_done_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == BUSY_I) begin
                        i_done_d  = 1'b1;
                        i_rdata_d = '0;
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = '0;
                    end
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            wdog_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            wdog_q      <= wdog_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign i_done     = i_done_q;
    assign d_done     = d_done_q;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign err        = err_q;
    assign fetch_wait = i_req & ~i_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios, then randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MS = 4;
    localparam int TO = 64;

    logic          clk;
    logic          rst;
    logic          halt_sys;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_done;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_done;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          fetch_wait;
    logic          err;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_STREAK(MS), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .halt_sys(halt_sys),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .fetch_wait(fetch_wait), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the memory (0 none, 1 fetch, 2 data) and how long it has held it.
    int            m_owner;
    int            m_cycles;
    int            m_streak;
    logic          e_mem_req, e_mem_we, e_i_done, e_d_done, e_err;
    logic [AW-1:0] e_mem_addr;
    logic [DW-1:0] e_mem_wdata, e_i_rdata, e_d_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner     = 0;
        m_cycles    = 0;
        m_streak    = 0;
        e_mem_req   = 1'b0;
        e_mem_we    = 1'b0;
        e_mem_addr  = '0;
        e_mem_wdata = '0;
        e_i_done    = 1'b0;
        e_d_done    = 1'b0;
        e_i_rdata   = '0;
        e_d_rdata   = '0;
        e_err       = 1'b0;
    endtask

    task automatic model_edge();
        logic ni_done, nd_done, nerr, iw, dw;
        int   win;
        ni_done = 1'b0;
        nd_done = 1'b0;
        nerr    = 1'b0;
        win     = 0;
        if (!rst) begin
            model_reset();
        end else begin
            if (m_owner == 0) begin
                if (!halt_sys) begin
                    iw = i_req && !e_i_done;
                    dw = d_req && !e_d_done;
                    if (iw && dw)  win = (m_streak < MS) ? 2 : 1;
                    else if (dw)   win = 2;
                    else if (iw)   win = 1;
                    if (win == 1 || !i_req)     m_streak = 0;
                    else if (win == 2 && iw)    m_streak = m_streak + 1;
                    if (win == 1) begin
                        e_mem_req = 1'b1; e_mem_we = 1'b0;
                        e_mem_addr = i_addr; e_mem_wdata = '0;
                        m_owner = 1; m_cycles = 0;
                    end else if (win == 2) begin
                        e_mem_req = 1'b1; e_mem_we = d_we;
                        e_mem_addr = d_addr; e_mem_wdata = d_wdata;
                        m_owner = 2; m_cycles = 0;
                    end
                end
            end else begin
                m_cycles = m_cycles + 1;
                if (mem_ready) begin
                    e_mem_req = 1'b0;
                    if (m_owner == 1) begin
                        ni_done = 1'b1; e_i_rdata = mem_rdata;
                    end else begin
                        nd_done = 1'b1;
                        if (!e_mem_we) e_d_rdata = mem_rdata;
                    end
                    m_owner = 0;
                end else if (m_cycles == TO) begin
                    e_mem_req = 1'b0;
                    nerr = 1'b1;
                    if (m_owner == 1) begin
                        ni_done = 1'b1; e_i_rdata = '0;
                    end else begin
                        nd_done = 1'b1; e_d_rdata = '0;
                    end
                    m_owner = 0;
                end
            end
            e_i_done = ni_done;
            e_d_done = nd_done;
            e_err    = nerr;
        end
    endtask

    task automatic check_all();
        chk("mem_req",    mem_req,    e_mem_req);
        chk("mem_we",     mem_we,     e_mem_we);
        chk("mem_addr",   mem_addr,   e_mem_addr);
        chk("mem_wdata",  mem_wdata,  e_mem_wdata);
        chk("i_done",     i_done,     e_i_done);
        chk("d_done",     d_done,     e_d_done);
        chk("i_rdata",    i_rdata,    e_i_rdata);
        chk("d_rdata",    d_rdata,    e_d_rdata);
        chk("err",        err,        e_err);
        chk("fetch_wait", fetch_wait, i_req & ~e_i_done);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        int unsigned n;
        int unsigned mode, halt_pct;
        rst = 1'b0; halt_sys = 1'b0; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        tick();
        tick();
        rst = 1'b1;

        // Single fetch, zero-wait memory
        i_req = 1'b1; i_addr = 16'h0010; mem_ready = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        chk("fetch_grant", mem_req, 1'b1);
        chk("fetch_wait_busy", fetch_wait, 1'b1);
        tick();
        chk("fetch_done", i_done, 1'b1);
        chk("fetch_rdata", i_rdata, 16'hBEEF);
        chk("fetch_wait_done", fetch_wait, 1'b0);
        i_req = 1'b0;
        tick();
        chk("fetch_done_pulse", i_done, 1'b0);

        // Store with three wait states
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234; mem_ready = 1'b0;
        tick();
        for (int unsigned k = 0; k < 3; k++) begin
            tick();
            chk("store_addr_hold", mem_addr, 16'h0200);
            chk("store_data_hold", mem_wdata, 16'h1234);
            chk("store_we", mem_we, 1'b1);
        end
        mem_ready = 1'b1; mem_rdata = 16'h7777;
        tick();
        chk("store_done", d_done, 1'b1);
        chk("store_rdata_kept", d_rdata, 16'h0000);
        d_req = 1'b0; mem_ready = 1'b0;
        tick();

        // Load, then a load the memory never answers
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0400; mem_ready = 1'b1; mem_rdata = 16'hA5A5;
        tick();
        tick();
        chk("load_rdata", d_rdata, 16'hA5A5);
        d_req = 1'b0; mem_ready = 1'b0;
        tick();
        d_req = 1'b1; d_addr = 16'h0300;
        tick();
        n = 0;
        while (d_done !== 1'b1 && n < 100) begin
            mem_rdata = 16'($urandom);
            tick();
            n++;
        end
        chk("timeout_cycles", n, 64);
        chk("timeout_err", err, 1'b1);
        chk("timeout_rdata", d_rdata, 16'h0000);
        d_req = 1'b0;
        tick();
        chk("timeout_err_pulse", err, 1'b0);

        // halt_sys raised while a fetch is in flight and data waits
        i_req = 1'b1; i_addr = 16'h0020;
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0500; halt_sys = 1'b1;
        tick();
        mem_ready = 1'b1; mem_rdata = 16'h1111;
        tick();
        chk("halt_fetch_done", i_done, 1'b1);
        i_req = 1'b0; mem_ready = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            tick();
            chk("halt_no_grant", mem_req, 1'b0);
        end
        halt_sys = 1'b0;
        tick();
        chk("halt_release_grant", mem_req, 1'b1);
        chk("halt_release_addr", mem_addr, 16'h0500);
        mem_ready = 1'b1;
        tick();
        d_req = 1'b0; mem_ready = 1'b0;
        tick();

        // Asynchronous reset in the middle of a data access
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0600; d_wdata = 16'h5555;
        tick();
        tick();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_async_req", mem_req, 1'b0);
        tick();
        rst = 1'b1; i_req = 1'b1; i_addr = 16'h0030;
        tick();
        chk("rst_prio_we", mem_we, 1'b1);
        chk("rst_prio_addr", mem_addr, 16'h0600);
        mem_ready = 1'b1;
        tick();
        d_req = 1'b0;
        tick();
        tick();
        i_req = 1'b0; mem_ready = 1'b0;
        tick();

        // Randomized traffic in segments with different memory and halt behaviour
        mode = 1; halt_pct = 10;
        for (int unsigned cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 200 == 0) begin
                mode     = $urandom_range(0, 4);
                halt_pct = ($urandom_range(0, 1) == 0) ? 10 : 50;
            end
            case (mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = ($urandom_range(0, 1) == 0);
                2:       mem_ready = ($urandom_range(0, 3) == 0);
                3:       mem_ready = 1'b0;
                default: mem_ready = ($urandom_range(0, 69) == 0);
            endcase
            mem_rdata = 16'($urandom);
            halt_sys  = ($urandom_range(0, 99) < halt_pct);
            if (!i_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    i_req = 1'b1; i_addr = 16'($urandom);
                end
            end else if (e_i_done) begin
                if ($urandom_range(0, 1) == 0) i_req = 1'b0;
                else i_addr = 16'($urandom);
            end
            if (!d_req) begin
                if ($urandom_range(0, 1) == 0) begin
                    d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                    d_addr = 16'($urandom); d_wdata = 16'($urandom);
                end
            end else if (e_d_done) begin
                if ($urandom_range(0, 3) == 0) begin
                    d_req = 1'b0;
                end else begin
                    d_we = 1'($urandom_range(0, 1));
                    d_addr = 16'($urandom); d_wdata = 16'($urandom);
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
